// File: rtl/frame_buffer_writer_if.sv
// Host byte stream plus buffer write port of the frame buffer writer.
// Latency: none, this file only bundles the signals.
// Backpressure: s_ready from the writer side qualifies each s_valid beat.
interface frame_buffer_writer_if;
    logic        s_valid;
    logic        s_sof;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        buf0_wr_en;
    logic        buf1_wr_en;
    logic [21:0] wr_addr;
    logic [7:0]  wr_data;

    // Writer side: consumes the host stream, drives the buffer write port.
    modport master (
        input  s_valid, s_sof, s_data,
        output s_ready, buf0_wr_en, buf1_wr_en, wr_addr, wr_data
    );

    // Environment side: host stream source and buffer memory sink.
    modport slave (
        output s_valid, s_sof, s_data,
        input  s_ready, buf0_wr_en, buf1_wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/frame_buffer_writer.sv
// Frame buffer writer: packs host RGB bytes into one of two ping-pong frame buffers.
// Latency: one cycle from accepted beat to registered buffer strobe, address and data.
// Backpressure: s_ready follows write permission of the buffer being filled; low in IDLE.
module frame_buffer_writer (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we0_in,
    input  logic                  we1_in,
    input  logic                  rel0,
    input  logic                  rel1,
    input  logic [9:0]            aip,
    input  logic [9:0]            ail,
    frame_buffer_writer_if.master bus,
    output logic                  buf0_full,
    output logic                  buf1_full,
    output logic                  frame_drop
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [21:0] len_now;
    logic [21:0] len_q;
    logic [21:0] cnt_q;
    logic        act_we;
    logic        accept;
    logic        discard;
    logic        resync;
    logic        do_write;
    logic        last;
    logic        abort;

    // Bytes per frame; the maximum 1023*1023*3 still fits in 22 bits.
    assign len_now = 22'(aip) * 22'(ail) * 22'd3;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: buffer 0 wins a grant tie; leave a fill on completion or lost permission.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (we0_in && !buf0_full && len_now != '0)      state_nxt = FILL0;
                else if (we1_in && !buf1_full && len_now != '0) state_nxt = FILL1;
            end
            FILL0, FILL1: begin
                if (abort || last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat decode: accept, discard before first SOF, resync on a stray SOF, frame end.
    always_comb begin
        act_we = 1'b0;
        case (state)
            FILL0:   act_we = we0_in;
            FILL1:   act_we = we1_in;
            default: act_we = 1'b0;
        endcase
        accept   = bus.s_valid && act_we;
        discard  = accept && !bus.s_sof && (cnt_q == '0);
        resync   = accept && bus.s_sof && (cnt_q != '0);
        do_write = accept && !discard;
        last     = do_write && !resync && (cnt_q == len_q - 22'd1);
        abort    = (state != IDLE) && !act_we;
    end

    assign bus.s_ready = act_we;

    // Length latch and byte counter; both refreshed while idle so every fill starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (state == IDLE) begin
            len_q <= len_now;
            cnt_q <= '0;
        end else if (do_write) begin
            cnt_q <= resync ? 22'd1 : cnt_q + 22'd1;
        end
    end

    // Registered write port: one strobe per written byte, address/data held between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.buf0_wr_en <= 1'b0;
            bus.buf1_wr_en <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
        end else begin
            bus.buf0_wr_en <= do_write && (state == FILL0);
            bus.buf1_wr_en <= do_write && (state == FILL1);
            if (do_write) begin
                bus.wr_addr <= resync ? '0 : cnt_q;
                bus.wr_data <= bus.s_data;
            end
        end
    end

    // Full flags and drop pulse; a completing write beats a same-cycle release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf0_full  <= 1'b0;
            buf1_full  <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= resync || abort;
            if (last && state == FILL0) buf0_full <= 1'b1;
            else if (rel0)              buf0_full <= 1'b0;
            if (last && state == FILL1) buf1_full <= 1'b1;
            else if (rel1)              buf1_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Testbench for frame_buffer_writer: directed scenarios plus randomized frames.
// Expected writes come from a beat-level frame model and are checked by a monitor.
// Host stream is driven on the falling edge and outputs are sampled there too.
module tb_frame_buffer_writer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we0_in = 1'b0;
    logic       we1_in = 1'b0;
    logic       rel0 = 1'b0;
    logic       rel1 = 1'b0;
    logic [9:0] aip = '0;
    logic [9:0] ail = '0;
    logic       buf0_full;
    logic       buf1_full;
    logic       frame_drop;

    frame_buffer_writer_if bus();

    frame_buffer_writer dut (
        .clk        (clk),
        .reset      (reset),
        .we0_in     (we0_in),
        .we1_in     (we1_in),
        .rel0       (rel0),
        .rel1       (rel1),
        .aip        (aip),
        .ail        (ail),
        .bus        (bus),
        .buf0_full  (buf0_full),
        .buf1_full  (buf1_full),
        .frame_drop (frame_drop)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          drop_seen = 0;
    int          exp_drops = 0;
    logic [30:0] exp_q[$];

    // Frame model: which buffer is filling, bytes placed so far, frame length.
    int   m_cnt = 0;
    int   m_len = 0;
    logic m_buf = 1'b0;
    logic m_done = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write; count drop pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_drop) drop_seen++;
            if (bus.buf0_wr_en && bus.buf1_wr_en) begin
                checks++;
                errors++;
                $display("FAIL dual_strobe: both buffer strobes high at %0t", $time);
            end else if (bus.buf0_wr_en || bus.buf1_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: buf1=%0b addr %0d data 0x%0h, none expected",
                             bus.buf1_wr_en, bus.wr_addr, bus.wr_data);
                end else begin
                    check("write", {bus.buf1_wr_en, bus.wr_addr, bus.wr_data}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic start_fill(input logic b);
        m_buf  = b;
        m_cnt  = 0;
        m_done = 1'b0;
        m_len  = int'(aip) * int'(ail) * 3;
    endtask

    // Frame rules at byte level: drop noise before SOF, restart on stray SOF, finish at L.
    task automatic model_accept(input logic sof, input logic [7:0] d);
        if (m_cnt == 0 && !sof) return;
        if (sof && m_cnt != 0) begin
            exp_drops++;
            m_cnt = 0;
        end
        exp_q.push_back({m_buf, 22'(m_cnt), d});
        m_cnt++;
        if (m_cnt == m_len) m_done = 1'b1;
    endtask

    // Present one beat after `gap` idle cycles; returns just after the accepting edge.
    task automatic send_byte(input logic sof, input logic [7:0] d, input int gap);
        int waited = 0;
        repeat (gap) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
        end
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_sof   = sof;
        bus.s_data  = d;
        #1;
        while (!bus.s_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: s_ready %0b after %0d cycles, required 1", bus.s_ready, waited);
            bus.s_valid = 1'b0;
            return;
        end
        model_accept(sof, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic pulse_rel(input logic b);
        @(negedge clk);
        if (b) rel1 = 1'b1; else rel0 = 1'b1;
        @(negedge clk);
        rel0 = 1'b0;
        rel1 = 1'b0;
    endtask

    // Feed bytes until the model says the frame is complete; optional noise and resync.
    task automatic run_frame(input bit noise);
        int guard = 0;
        bit resynced = 1'b0;
        while (!m_done && guard < 300) begin
            guard++;
            if (noise && guard == 4) begin
                aip = 10'($urandom_range(1, 4));
                ail = 10'($urandom_range(1, 3));
            end
            if (m_cnt == 0) begin
                if (noise && $urandom_range(0, 3) == 0)
                    send_byte(1'b0, 8'($urandom), $urandom_range(0, 2));
                else
                    send_byte(1'b1, 8'($urandom), $urandom_range(0, 2));
            end else if (noise && !resynced && $urandom_range(0, 9) == 0) begin
                resynced = 1'b1;
                send_byte(1'b1, 8'($urandom), $urandom_range(0, 2));
            end else begin
                send_byte(1'b0, 8'($urandom), $urandom_range(0, 2));
            end
        end
        check("frame_complete", m_done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, bus.s_ready, 0);
        check({tag, "_wr_en0"}, bus.buf0_wr_en, 0);
        check({tag, "_wr_en1"}, bus.buf1_wr_en, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_full0"}, buf0_full, 0);
        check({tag, "_full1"}, buf1_full, 0);
        check({tag, "_drop"}, frame_drop, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_ready;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Basic fill of buffer 0 with 0x01..0x0C; release on the completing cycle.
        aip = 10'd2;
        ail = 10'd2;
        we0_in = 1'b1;
        start_fill(1'b0);
        for (int i = 1; i <= 11; i++) send_byte(i == 1, 8'(i), 0);
        rel0 = 1'b1;
        send_byte(1'b0, 8'd12, 0);
        rel0 = 1'b0;
        idle();
        check("basic_full0", buf0_full, 1);
        check("basic_ready_low", bus.s_ready, 0);

        // Ping-pong into buffer 1 while buffer 0 is held full.
        we0_in = 1'b0;
        we1_in = 1'b1;
        start_fill(1'b1);
        run_frame(1'b0);
        idle();
        check("pp_full1", buf1_full, 1);
        check("pp_full0_held", buf0_full, 1);
        pulse_rel(1'b0);
        check("pp_rel0", buf0_full, 0);
        check("pp_full1_kept", buf1_full, 1);

        // Resync: second SOF at byte 5 restarts the frame at address 0.
        we1_in = 1'b0;
        we0_in = 1'b1;
        start_fill(1'b0);
        for (int i = 0; i < 5; i++) send_byte(i == 0, 8'($urandom), 0);
        send_byte(1'b1, 8'hA5, 0);
        for (int i = 0; i < 10; i++) send_byte(1'b0, 8'($urandom), 0);
        idle();
        check("resync_not_full_early", buf0_full, 0);
        send_byte(1'b0, 8'h5A, 0);
        idle();
        check("resync_full0", buf0_full, 1);
        check("resync_drops", drop_seen, exp_drops);

        // Abort: permission drops after 7 bytes, then a re-grant restarts from address 0.
        pulse_rel(1'b0);
        start_fill(1'b0);
        for (int i = 0; i < 7; i++) send_byte(i == 0, 8'($urandom), 0);
        @(negedge clk);
        we0_in = 1'b0;
        bus.s_valid = 1'b0;
        exp_drops++;
        repeat (2) @(negedge clk);
        check("abort_drops", drop_seen, exp_drops);
        check("abort_full0", buf0_full, 0);
        check("abort_ready", bus.s_ready, 0);
        we0_in = 1'b1;
        start_fill(1'b0);
        run_frame(1'b0);
        idle();
        check("regrant_full0", buf0_full, 1);

        // Zero-length frame: no grant, no ready, no writes.
        aip = 10'd0;
        pulse_rel(1'b0);
        saw_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_sof   = 1'b1;
            bus.s_data  = 8'($urandom);
            #1;
            if (bus.s_ready) saw_ready = 1'b1;
        end
        idle();
        check("aip0_ready", saw_ready, 0);

        // Reset at byte 4 of a fill: everything clears at once, no drop pulse.
        aip = 10'd2;
        start_fill(1'b0);
        for (int i = 0; i < 4; i++) send_byte(i == 0, 8'($urandom), 0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        bus.s_valid = 1'b0;
        we0_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_drops", drop_seen, exp_drops);

        // Randomized frames: random sizes, gaps, pre-SOF noise, resyncs, mid-fill size changes.
        for (int f = 0; f < 16; f++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            aip = 10'($urandom_range(1, 4));
            ail = 10'($urandom_range(1, 3));
            start_fill(b);
            we0_in = !b;
            we1_in = b;
            run_frame(1'b1);
            idle();
            check("rand_full", b ? buf1_full : buf0_full, 1);
            check("rand_ready_low", bus.s_ready, 0);
            we0_in = 1'b0;
            we1_in = 1'b0;
            pulse_rel(b);
            check("rand_rel", b ? buf1_full : buf0_full, 0);
        end
        repeat (4) @(negedge clk);
        check("rand_drops", drop_seen, exp_drops);
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_buffer_writer.md
FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 The block SHALL use clock clk and reset reset, asynchronous, active-high.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- we0_in  in  1  write permission for buffer 0, from display controller
- we1_in  in  1  write permission for buffer 1, from display controller
- rel0  in  1  one-cycle pulse: buffer 0 fully read (controller address reset)
- rel1  in  1  one-cycle pulse: buffer 1 fully read
- aip  in  10  active pixels per line
- ail  in  10  active lines per frame
- s_valid  in  1  host byte valid
- s_sof  in  1  host byte is first byte of a frame (R of pixel 0)
- s_data  in  8  host colour byte; R, G, B order per pixel
- s_ready  out  1  block accepts host byte this cycle
- buf0_wr_en  out  1  write strobe, buffer 0
- buf1_wr_en  out  1  write strobe, buffer 1
- wr_addr  out  22  byte address into selected buffer
- wr_data  out  8  byte to write
- buf0_full  out  1  buffer 0 holds a complete frame
- buf1_full  out  1  buffer 1 holds a complete frame
- frame_drop  out  1  one-cycle pulse: partial frame discarded

Function
REQ-003 Frame length L SHALL be aip*ail*3, computed at 22 bits, and latched on entry to FILL0/FILL1; aip and ail changes mid-fill SHALL have no effect.
REQ-004 States SHALL be IDLE, FILL0, FILL1.
REQ-005 In IDLE, the block SHALL go to FILL0 when we0_in=1, buf0_full=0 and L!=0; otherwise to FILL1 when we1_in=1, buf1_full=0 and L!=0; otherwise it stays in IDLE. Buffer 0 takes priority.
REQ-006 Entering FILLn SHALL clear the internal address counter to 0.
REQ-007 s_ready SHALL be 1 only in FILL0 with we0_in=1, or in FILL1 with we1_in=1; it is 0 in IDLE.
REQ-008 A beat is accepted when s_valid=1 and s_ready=1.
REQ-009 Until the first beat with s_sof=1, the block SHALL discard beats that have s_sof=0 while the counter is 0, accepting them with no write.
REQ-010 Each accepted, non-discarded beat SHALL produce one write on the following cycle, with registered outputs: bufn_wr_en=1, wr_addr=counter value at acceptance, wr_data=s_data.
REQ-011 The counter SHALL then increment.
REQ-012 Write strobes SHALL be 0 in every cycle that follows a non-accepted beat.
REQ-013 When the accepted beat is at address L-1, the next cycle SHALL set bufn_full=1 and return to IDLE; s_ready SHALL be 0 in that cycle.
REQ-014 When s_sof=1 is accepted while the counter is non-zero, the block SHALL pulse frame_drop and write the byte at address 0; the counter becomes 1 (resync).
REQ-015 When we-permission for the active buffer drops mid-fill, the block SHALL pulse frame_drop and return to IDLE; bufn_full stays 0.
REQ-016 rel0 and rel1 SHALL clear buf0_full and buf1_full respectively on the next edge.
REQ-017 When release and fill-completion target the same flag in the same cycle, completion SHALL win and the flag is 1.
REQ-018 buf0_wr_en and buf1_wr_en SHALL never be 1 in the same cycle.
REQ-019 The maximum L is 3,139,587; the counter SHALL not wrap within a frame.

Reset
REQ-020 On reset, the state SHALL be IDLE, the counter 0, and all outputs 0, including s_ready, strobes, wr_addr, wr_data, full flags and frame_drop.
REQ-021 Reset asserted mid-fill SHALL abandon the frame without a frame_drop pulse; full flags are cleared.

Verification
REQ-022 Basic fill: aip=2, ail=2, we0_in=1, 12 bytes 0x01..0x0C with s_sof on first -> buf0_wr_en at addr 0..11 with matching data, buf0_full=1 one cycle after 12th acceptance, then s_ready=0.
REQ-023 Ping-pong: buf0_full=1, we0_in=0, we1_in=1, 12 bytes -> only buf1_wr_en asserted, buf1_full=1; rel0 pulse -> buf0_full=0 next cycle.
REQ-024 Resync: aip=2, ail=2, s_sof at bytes 0 and 5 -> frame_drop pulse once, second s_sof byte written at addr 0, full after 12 further bytes.
REQ-025 Abort: we0_in dropped after 7 bytes -> frame_drop pulse, state IDLE, buf0_full=0; re-grant -> fill restarts at addr 0.
REQ-026 Edge cases: aip=0 -> s_ready stays 0, no writes. rel0 coincident with completing write of buffer 0 -> buf0_full=1. Reset at byte 4 -> all outputs 0 immediately.
